rob_multi: RTL and testbench

- Parametrised reorder buffer for the out-of-order core: allocates up to ISSUE_N tags per cycle in program order and captures results from CDB_N broadcast buses.
- Retires up to COMMIT_N completed head entries per cycle, in order, to the architectural register file.
- Provides READ_N operand lookup ports for rename/dispatch, plus occupancy tracking and a full flush for misprediction recovery.

---
 rtl/rob_multi.sv | 151 +++++++++++++++
 tb/tb_rob_multi.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rob_multi.sv
// Multi-lane reorder buffer: in-order allocate/retire, CDB result capture, operand lookup ports.
// Build option: define ROB_CDB_BYPASS_EN to forward same-cycle CDB results to read and commit ports.
module rob_multi #(
    parameter int unsigned ROB_W    = 4,
    parameter int unsigned ISSUE_N  = 2,
    parameter int unsigned COMMIT_N = 2,
    parameter int unsigned CDB_N    = 2,
    parameter int unsigned READ_N   = 4,
    parameter int unsigned ARCH_W   = 6,
    parameter int unsigned DATA_W   = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [ISSUE_N-1:0]           issue_valid,
    input  logic [ISSUE_N*ARCH_W-1:0]    issue_arch,
    output logic                         issue_ready,
    output logic [ISSUE_N*ROB_W-1:0]     issue_tag,
    input  logic [CDB_N-1:0]             cdb_valid,
    input  logic [CDB_N*ROB_W-1:0]       cdb_tag,
    input  logic [CDB_N*DATA_W-1:0]      cdb_data,
    input  logic [READ_N*ROB_W-1:0]      read_tag,
    output logic [READ_N-1:0]            read_done,
    output logic [READ_N*DATA_W-1:0]     read_data,
    output logic [COMMIT_N-1:0]          commit_valid,
    input  logic [COMMIT_N-1:0]          commit_ready,
    output logic [COMMIT_N*ARCH_W-1:0]   commit_arch,
    output logic [COMMIT_N*ROB_W-1:0]    commit_tag,
    output logic [COMMIT_N*DATA_W-1:0]   commit_data,
    output logic [ROB_W:0]               count
);
    localparam int unsigned DEPTH = 1 << ROB_W;
    localparam int unsigned CNT_W = ROB_W + 1;

    logic [ROB_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;
    logic [DEPTH-1:0]  busy_q, done_q;
    logic [ARCH_W-1:0] arch_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [DEPTH-1:0]  cdb_hit;
    logic [DATA_W-1:0] cdb_wdata [DEPTH];
    logic [DEPTH-1:0]  eff_done;
    logic [DATA_W-1:0] eff_data [DEPTH];
    logic [CNT_W-1:0]  n_iss, n_com;

    assign count       = count_q;
    assign issue_ready = count_q <= CNT_W'(DEPTH - ISSUE_N);

    // Per-entry CDB match; the highest bus index wins a tag collision.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            cdb_hit[e]   = 1'b0;
            cdb_wdata[e] = '0;
            for (int j = 0; j < CDB_N; j++) begin
                if (cdb_valid[j] && cdb_tag[j*ROB_W +: ROB_W] == ROB_W'(e)) begin
                    cdb_hit[e]   = 1'b1;
                    cdb_wdata[e] = cdb_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Entry view seen by the read and commit ports.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
`ifdef ROB_CDB_BYPASS_EN
            eff_done[e] = done_q[e] | cdb_hit[e];
            eff_data[e] = cdb_hit[e] ? cdb_wdata[e] : data_q[e];
`else
            eff_done[e] = done_q[e];
            eff_data[e] = data_q[e];
`endif
        end
    end

    always_comb begin
        n_iss = '0;
        for (int i = 0; i < ISSUE_N; i++) begin
            issue_tag[i*ROB_W +: ROB_W] = tail_q + ROB_W'(i);
            if (issue_valid[i]) n_iss = n_iss + CNT_W'(1);
        end
        if (!issue_ready) n_iss = '0;
    end

    always_comb begin
        for (int r = 0; r < READ_N; r++) begin
            read_done[r]                = eff_done[read_tag[r*ROB_W +: ROB_W]];
            read_data[r*DATA_W +: DATA_W] = eff_data[read_tag[r*ROB_W +: ROB_W]];
        end
    end

    // Retire lanes: each lane needs all lower lanes valid; acceptance stops at the first gap.
    always_comb begin
        logic             chain;
        logic             acc;
        logic [ROB_W-1:0] idx;
        chain = 1'b1;
        acc   = 1'b1;
        n_com = '0;
        idx   = '0;
        for (int k = 0; k < COMMIT_N; k++) begin
            idx   = head_q + ROB_W'(k);
            chain = chain && (CNT_W'(k) < count_q) && busy_q[idx] && eff_done[idx];
            commit_valid[k]                 = chain;
            commit_arch[k*ARCH_W +: ARCH_W] = arch_q[idx];
            commit_tag[k*ROB_W +: ROB_W]    = idx;
            commit_data[k*DATA_W +: DATA_W] = eff_data[idx];
            acc = acc && chain && commit_ready[k];
            if (acc) n_com = n_com + CNT_W'(1);
        end
    end

    // Allocation, then CDB capture (wins over allocation), then retirement clears.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            busy_q  <= '0;
            done_q  <= '0;
        end else begin
            for (int i = 0; i < ISSUE_N; i++) begin
                if (issue_ready && issue_valid[i]) begin
                    busy_q[tail_q + ROB_W'(i)] <= 1'b1;
                    done_q[tail_q + ROB_W'(i)] <= 1'b0;
                    arch_q[tail_q + ROB_W'(i)] <= issue_arch[i*ARCH_W +: ARCH_W];
                end
            end
            for (int e = 0; e < DEPTH; e++) begin
                if (cdb_hit[e]) begin
                    done_q[e] <= 1'b1;
                    data_q[e] <= cdb_wdata[e];
                end
            end
            for (int k = 0; k < COMMIT_N; k++) begin
                if (CNT_W'(k) < n_com) begin
                    busy_q[head_q + ROB_W'(k)] <= 1'b0;
                    done_q[head_q + ROB_W'(k)] <= 1'b0;
                end
            end
            head_q  <= head_q + ROB_W'(n_com);
            tail_q  <= tail_q + ROB_W'(n_iss);
            count_q <= count_q + n_iss - n_com;
        end
    end

    a_issue_thermo: assert property (@(posedge clk) disable iff (reset)
        ((issue_valid & (issue_valid + ISSUE_N'(1))) == '0));

endmodule

// File: tb/tb_rob_multi.sv
// Directed bench for rob_multi with default parameters; expectations are hand-computed.
module tb_rob_multi;
`ifdef ROB_CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset, flush;
    logic [1:0]   issue_valid;
    logic [11:0]  issue_arch;
    logic         issue_ready;
    logic [7:0]   issue_tag;
    logic [1:0]   cdb_valid;
    logic [7:0]   cdb_tag;
    logic [63:0]  cdb_data;
    logic [15:0]  read_tag;
    logic [3:0]   read_done;
    logic [127:0] read_data;
    logic [1:0]   commit_valid;
    logic [1:0]   commit_ready;
    logic [11:0]  commit_arch;
    logic [7:0]   commit_tag;
    logic [63:0]  commit_data;
    logic [4:0]   count;

    int passed = 0;
    int total  = 0;

    rob_multi dut (
        .clk(clk), .reset(reset), .flush(flush),
        .issue_valid(issue_valid), .issue_arch(issue_arch),
        .issue_ready(issue_ready), .issue_tag(issue_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .read_tag(read_tag), .read_done(read_done), .read_data(read_data),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_arch(commit_arch), .commit_tag(commit_tag),
        .commit_data(commit_data), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = '0;
        cdb_valid   = '0;
        flush       = 1'b0;
    endtask

    task automatic cdb(input int b, input logic [3:0] t, input logic [31:0] d);
        cdb_valid[b]          = 1'b1;
        cdb_tag[b*4 +: 4]     = t;
        cdb_data[b*32 +: 32]  = d;
    endtask

    initial begin
        logic [7:0] exp_tag;
        reset = 1'b1; flush = 1'b0; issue_valid = '0; issue_arch = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0; read_tag = '0; commit_ready = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_count", count, 5'd0);
        chk("rst_ready", issue_ready, 1'b1);
        chk("rst_cvalid", commit_valid, 2'b00);
        chk("rst_itag", issue_tag, 8'h10);

        // Fill all 16 entries two per cycle.
        issue_arch = {6'd5, 6'd3};
        for (int c = 0; c < 8; c++) begin
            issue_valid = 2'b11;
            exp_tag = {4'(2*c+1), 4'(2*c)};
            #1;
            chk("fill_itag", issue_tag, exp_tag);
            chk("fill_ready", issue_ready, 1'b1);
            tick();
        end
        idle(); #1;
        chk("full_count", count, 5'd16);
        chk("full_ready", issue_ready, 1'b0);
        issue_valid = 2'b11;
        tick(); idle(); #1;
        chk("full_ignored", count, 5'd16);
        chk("full_itag", issue_tag, 8'h10);

        // Out-of-order completion of the two oldest entries.
        cdb(0, 4'd1, 32'hAA);
        tick(); idle(); #1;
        chk("head_pending", commit_valid, 2'b00);
        cdb(1, 4'd0, 32'h55);
        tick(); idle(); #1;
        chk("cv_both", commit_valid, 2'b11);
        chk("carch", commit_arch, {6'd5, 6'd3});
        chk("cdata", commit_data, {32'hAA, 32'h55});
        chk("ctag", commit_tag, 8'h10);
        commit_ready = 2'b11;
        tick(); commit_ready = 2'b00; #1;
        chk("commit2_count", count, 5'd14);
        chk("commit2_cv", commit_valid, 2'b00);

        // Complete and retire tags 2..13, leaving head at 14.
        for (int k = 1; k < 7; k++) begin
            cdb(0, 4'(2*k), 32'(2*k));
            cdb(1, 4'(2*k+1), 32'(2*k+1));
            tick(); idle();
        end
        commit_ready = 2'b11;
        repeat (6) tick();
        commit_ready = 2'b00; #1;
        chk("drain_count", count, 5'd2);
        chk("drain_ctag", commit_tag, 8'hFE);
        chk("drain_cv", commit_valid, 2'b00);

        // Wrap: allocate tags 0..3, complete 14,15,0,1.
        issue_valid = 2'b11; tick(); tick(); idle();
        cdb(0, 4'd14, 32'hE0); cdb(1, 4'd15, 32'hF0); tick(); idle();
        cdb(0, 4'd0, 32'hA0); cdb(1, 4'd1, 32'hB0); tick(); idle(); #1;
        chk("wrap_count", count, 5'd6);
        chk("wrap_cv", commit_valid, 2'b11);
        chk("wrap_ctag", commit_tag, 8'hFE);
        chk("wrap_cdata", commit_data, {32'hF0, 32'hE0});
        commit_ready = 2'b01;
        tick(); commit_ready = 2'b10; #1;
        chk("lane0only_count", count, 5'd5);
        chk("lane0only_ctag", commit_tag, 8'h0F);
        tick(); commit_ready = 2'b11; #1;
        chk("gap_count", count, 5'd5);
        tick(); commit_ready = 2'b01; #1;
        chk("wrap2_count", count, 5'd3);
        chk("wrap2_cv", commit_valid, 2'b01);
        chk("wrap2_ctag", commit_tag, 8'h21);
        chk("wrap2_cdata0", commit_data[31:0], 32'hB0);
        tick(); commit_ready = 2'b00; #1;
        chk("wrap3_count", count, 5'd2);

        // Issue tag 4 with a same-cycle broadcast to it.
        read_tag[3:0] = 4'd4; #1;
        chk("rd_before", read_done[0], 1'b0);
        issue_valid = 2'b01; issue_arch = {6'd0, 6'd7};
        cdb(0, 4'd4, 32'h1234); #1;
        chk("rd_samecyc", read_done[0], BYP);
        tick(); idle(); #1;
        chk("rd_done", read_done[0], 1'b1);
        chk("rd_data", read_data[31:0], 32'h1234);
        chk("rd_count", count, 5'd3);

        // Two buses on one tag: higher bus index wins.
        cdb(0, 4'd2, 32'h1111); cdb(1, 4'd2, 32'h2222);
        tick(); idle();
        read_tag[7:4] = 4'd2; read_tag[11:8] = 4'd3; #1;
        chk("dup_done", read_done[1], 1'b1);
        chk("dup_data", read_data[63:32], 32'h2222);
        chk("rd_notdone", read_done[2], 1'b0);
        chk("head2_cv", commit_valid, 2'b01);
        chk("head2_arch", commit_arch[5:0], 6'd3);
        commit_ready = 2'b01;
        tick(); commit_ready = 2'b00; #1;
        chk("head3_count", count, 5'd2);

        // Head entry completes by CDB: visible same cycle only with bypass.
        cdb(1, 4'd3, 32'h77); #1;
        chk("byp_cv", commit_valid, BYP ? 2'b11 : 2'b00);
        tick(); idle(); #1;
        chk("late_cv", commit_valid, 2'b11);
        chk("late_cdata", commit_data, {32'h1234, 32'h77});
        chk("late_ctag", commit_tag, 8'h43);
        commit_ready = 2'b11;
        tick(); commit_ready = 2'b00; #1;
        chk("empty_count", count, 5'd0);

        // Flush dominates simultaneous issue and CDB.
        issue_arch = {6'd5, 6'd3};
        issue_valid = 2'b11; repeat (3) tick(); idle(); #1;
        chk("inflight_count", count, 5'd6);
        flush = 1'b1; issue_valid = 2'b11; cdb(0, 4'd11, 32'h9);
        tick(); idle();
        read_tag[3:0] = 4'd11; #1;
        chk("flush_count", count, 5'd0);
        chk("flush_cv", commit_valid, 2'b00);
        chk("flush_itag", issue_tag, 8'h10);
        chk("flush_ready", issue_ready, 1'b1);
        chk("flush_rd", read_done[0], 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
